// File: rtl/setpoint_entry.sv
// rtl/setpoint_entry.sv - PS/2 keypad setpoint entry: two-digit decimal edit buffer committed to threshold A
module setpoint_entry #(
   parameter int N       = 5,
   parameter int MAX_VAL = 31,
   parameter int DEFAULT = 20
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [7:0]   code,
   input  logic         code_valid,
   output logic [N-1:0] A,
   output logic         commit,
   output logic         err,
   output logic [6:0]   entry_val,
   output logic [1:0]   digit_cnt
);

   localparam logic [6:0]   MAX7 = 7'(MAX_VAL);
   localparam logic [N-1:0] DEF  = N'(DEFAULT);

   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

   state_t     state;
   logic       brk;
   logic       ext;
   logic       is_digit;
   logic [3:0] digit;
   logic       take_plain;
   logic       enter;
   logic [6:0] times10;
   logic [6:0] div10;

   assign digit_cnt = state;

   always_comb begin
      is_digit = 1'b1;
      digit    = 4'd0;
      case (code)
         8'h45: digit = 4'd0;
         8'h16: digit = 4'd1;
         8'h1E: digit = 4'd2;
         8'h26: digit = 4'd3;
         8'h25: digit = 4'd4;
         8'h2E: digit = 4'd5;
         8'h36: digit = 4'd6;
         8'h3D: digit = 4'd7;
         8'h3E: digit = 4'd8;
         8'h46: digit = 4'd9;
         default: is_digit = 1'b0;
      endcase
   end

   // A byte reaches the entry logic only when no release/extended prefix is pending.
   assign take_plain = code_valid && code != 8'hF0 && !brk && code != 8'hE0 && !ext;
   assign enter      = (take_plain && code == 8'h5A) ||
                       (code_valid && code == 8'h5A && !brk && ext);
   // Only used in ONE, where entry_val <= 9, so 7 bits cannot overflow.
   assign times10    = {entry_val[3:0], 3'b000} + {entry_val[5:0], 1'b0};
   assign div10      = entry_val / 7'd10;

   always_ff @(posedge clk) begin
      if (!reset) begin
         A         <= DEF;
         commit    <= 1'b0;
         err       <= 1'b0;
         entry_val <= 7'd0;
         state     <= EMPTY;
         brk       <= 1'b0;
         ext       <= 1'b0;
      end else begin
         commit <= 1'b0;
         err    <= 1'b0;
         if (code_valid) begin
            if (code == 8'hF0) begin
               brk <= 1'b1;
            end else if (brk) begin
               brk <= 1'b0;
               ext <= 1'b0;
            end else if (code == 8'hE0) begin
               ext <= 1'b1;
            end else if (ext) begin
               ext <= 1'b0;
            end
         end
         if (enter) begin
            if (state == EMPTY) begin
               err <= 1'b1;
            end else begin
               // Range check on the full 7-bit value before truncating to N bits.
               if (entry_val <= MAX7) begin
                  A      <= entry_val[N-1:0];
                  commit <= 1'b1;
               end else begin
                  err <= 1'b1;
               end
               entry_val <= 7'd0;
               state     <= EMPTY;
            end
         end else if (take_plain) begin
            if (is_digit) begin
               case (state)
                  EMPTY: begin
                     entry_val <= {3'b000, digit};
                     state     <= ONE;
                  end
                  ONE: begin
                     entry_val <= times10 + {3'b000, digit};
                     state     <= TWO;
                  end
                  default: err <= 1'b1;
               endcase
            end else if (code == 8'h66) begin
               case (state)
                  TWO: begin
                     entry_val <= div10;
                     state     <= ONE;
                  end
                  ONE: begin
                     entry_val <= 7'd0;
                     state     <= EMPTY;
                  end
                  default: ;
               endcase
            end else if (code == 8'h76) begin
               entry_val <= 7'd0;
               state     <= EMPTY;
            end
         end
      end
   end

endmodule

// File: doc/setpoint_entry.md
Name: setpoint_entry

Overview:
Keyboard-side producer of the temperature threshold consumed by the 5-bit threshold comparator (D >= A). It takes decoded PS/2 set-2 scan-code bytes and accumulates up to two decimal digits. Backspace edits, Esc clears, and Enter commits the value to the registered setpoint A. Values outside 0..MAX_VAL are rejected with an error pulse.

Parameters:
N, 5, setpoint width; must match the comparator width.
MAX_VAL, 31, highest accepted setpoint; must be <= 2^N-1.
DEFAULT, 20, setpoint value after reset; must be <= MAX_VAL.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
reset  input  1  synchronous, active-low reset (reset==0 resets on the clock edge).
code  input  8  scan-code byte from the PS/2 receiver.
code_valid  input  1  one-cycle strobe; code is valid in this cycle.
A  output  N  committed setpoint; drives the comparator A input.
commit  output  1  one-cycle pulse; A was updated in this cycle.
err  output  1  one-cycle pulse; an entry or commit was rejected.
entry_val  output  7  current uncommitted entry value (0..99), for display.
digit_cnt  output  2  number of digits held in the entry (0..2).

Behaviour:
- Reset values: A=DEFAULT, commit=0, err=0, entry_val=0, digit_cnt=0, brk=0, ext=0. Reset mid-entry discards the entry and restores A to DEFAULT.
- All outputs are registered. The response appears on the clock edge after the code_valid cycle, so the latency is 1 cycle.
- Back-to-back strobes, one byte per cycle, must be handled with no loss.
- When code_valid=0, state holds and commit/err are 0.
- Prefix handling, in priority order:
  - Byte 0xF0 sets brk.
  - If brk=1, the next byte is consumed with no action (key release), and brk and ext are cleared.
  - Byte 0xE0 sets ext.
  - If ext=1 and brk=0, the next byte is treated as Enter if it is 0x5A; otherwise it is ignored. ext is then cleared.
- Digit codes: 0x45=0, 0x16=1, 0x1E=2, 0x26=3, 0x25=4, 0x2E=5, 0x36=6, 0x3D=7, 0x3E=8, 0x46=9.
- Entry state machine, with states EMPTY, ONE and TWO (digit_cnt = 0/1/2):
  - Digit in EMPTY: entry_val=d, go to ONE.
  - Digit in ONE: entry_val=entry_val*10+d, go to TWO.
  - Digit in TWO: ignored, err pulse, entry unchanged.
  - Backspace 0x66 in TWO: entry_val=entry_val/10, go to ONE.
  - Backspace 0x66 in ONE: entry_val=0, go to EMPTY.
  - Backspace 0x66 in EMPTY: no action.
  - Esc 0x76: entry_val=0, go to EMPTY. No err.
  - Enter 0x5A in ONE or TWO with entry_val<=MAX_VAL: A=entry_val[N-1:0], commit pulse, entry cleared, go to EMPTY.
  - Enter 0x5A in ONE or TWO with entry_val>MAX_VAL: A unchanged, err pulse, entry cleared, go to EMPTY.
  - Enter 0x5A in EMPTY: A unchanged, err pulse.
  - Any other byte: ignored, no pulse.
- Arithmetic: entry_val is 7 bits wide and never exceeds 99. The *10 uses a shift-add. Truncation to N bits happens only after the range check.
- commit and err are never asserted in the same cycle.

Test Plan:
1. Reset (reset=0 for 2 clk) -> A=20, entry_val=0, digit_cnt=0, commit=0, err=0.
2. Strobes 0x16 (1), 0x3E (8), 0x5A -> entry_val=1, then 18; A=18 with commit=1 for exactly 1 cycle, one cycle after the Enter strobe; then digit_cnt=0.
3. Strobes 0x26 (3), 0x2E (5), 0x5A -> entry 35 > 31: err=1 for 1 cycle, A stays 18, entry cleared. Then a third-digit case: 0x16, 0x16, 0x16 -> err on the third byte, entry_val=11.
4. Strobes 0x1E, 0xF0, 0x1E, 0x25, 0x66, 0x36, 0xE0, 0x5A on consecutive cycles -> the release byte is ignored; entry goes 2, 24, 2, 26; keypad Enter commits A=26.
5. Strobes 0x16, 0x76 (Esc), 0x5A -> entry cleared with no err, then err on Enter from EMPTY; A unchanged. Strobes 0xE0, 0xF0, 0x5A -> no commit, no err.
6. Strobes 0x16, 0x1E, then reset=0 held through the Enter strobe -> A=20, entry_val=0, no commit pulse.
